// File: rtl/alu_pkg.sv
// Shared ALU driver definitions: select codes, driver state, default width.
// Imported by alu_driver and alu_rsp_fifo.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } drv_state_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// 2-entry synchronous response FIFO; head shown while count > 0.
// Ports: clk, rst, push/push_data, pop, head, count.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int W = ALU_WIDTH + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;

  // Pop on empty is dropped; push only refused when full with no pop.
  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/alu_driver.sv
// Drives registered operands onto a combinational ALU, waits SETTLE
// cycles, captures the result into a 2-entry valid/ready response buffer.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_sel,
  output logic             busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("alu_driver: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  drv_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             push;
  logic [WIDTH+1:0] head;
  logic [1:0]       count;
  logic             accept;

  assign req_ready = !rst && (state_q == ST_IDLE) && (count != 2'd2);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    push      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = req_sel;
          cnt_d     = SETTLE_C;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Last settle edge: result is stable, capture it.
        if (cnt_q == 4'd1) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  alu_rsp_fifo #(
    .W (WIDTH + 2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({alu_out, alu_sel_q}),
    .pop       (rsp_ready),
    .head      (head),
    .count     (count)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = head[WIDTH+1:2];
  assign rsp_sel   = head[1:0];
  assign busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver with a behavioural ALU behind it.
// Instances: SETTLE=1 (main) and SETTLE=4 (timing).
module tb_alu_driver;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_sel;
  logic        busy;

  logic        s4_req_valid, s4_req_ready;
  logic [31:0] s4_req_a, s4_req_b;
  logic [1:0]  s4_req_sel;
  logic [31:0] s4_alu_a, s4_alu_b, s4_alu_out;
  logic [1:0]  s4_alu_sel;
  logic        s4_rsp_valid, s4_rsp_ready;
  logic [31:0] s4_rsp_data;
  logic [1:0]  s4_rsp_sel;
  logic        s4_busy;

  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out    = alu_f(alu_a, alu_b, alu_sel);
  assign s4_alu_out = alu_f(s4_alu_a, s4_alu_b, s4_alu_sel);

  alu_driver #(.WIDTH(32), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel),
    .busy(busy)
  );

  alu_driver #(.WIDTH(32), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(s4_req_valid), .req_ready(s4_req_ready),
    .req_a(s4_req_a), .req_b(s4_req_b), .req_sel(s4_req_sel),
    .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_sel(s4_alu_sel),
    .alu_out(s4_alu_out),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready),
    .rsp_data(s4_rsp_data), .rsp_sel(s4_rsp_sel),
    .busy(s4_busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic rnd_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: pop-and-compare on every handshake, push on every accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp got=%h exp=none", rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_sel", 32'(rsp_sel), 32'(e.s));
        end
      end
      if (req_valid && req_ready)
        exp_q.push_back('{alu_f(req_a, req_b, req_sel), req_sel});
      if (busy)
        chk("ready_in_wait", 32'(req_ready), 32'd0);
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s);
    req_a     = a;
    req_b     = b;
    req_sel   = s;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout got=no_accept exp=accept");
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    logic got_rdy;
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0;
    rsp_ready = 1'b0;
    s4_req_valid = 1'b0; s4_req_a = '0; s4_req_b = '0;
    s4_req_sel = '0; s4_rsp_ready = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_s4_req_ready", 32'(s4_req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_sel", 32'(rsp_sel), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // First op: operands next cycle, result one cycle later.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(32'h000003E8, 32'h000007D0, ALU_ADD);
    chk("t1_alu_a", alu_a, 32'h000003E8);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_no_early", 32'(rsp_valid), 32'd0);
    chk("t1_alu_b", alu_b, 32'h000007D0);
    chk("t1_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", rsp_data, 32'h00000BB8);
    chk("t1_rsp_sel", 32'(rsp_sel), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Back-to-back.
    @(posedge clk); #1;
    issue(32'h11111111, 32'h44220EA1, ALU_SUB);
    issue(32'hA0A0A0A0, 32'h00213120, ALU_AND);
    issue(32'hF0F0F0F0, 32'h15741674, ALU_OR);
    repeat (4) @(posedge clk);
    #1 chk("b2b_drain", exp_q.size(), 32'd0);

    // Backpressure.
    rsp_ready = 1'b0;
    issue(32'd5, 32'd7, ALU_ADD);
    issue(32'd9, 32'd4, ALU_SUB);
    req_a = 32'h0F0F0000; req_b = 32'h00F0F000; req_sel = ALU_OR;
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head", rsp_data, 32'd12);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    chk("bp_head2", rsp_data, 32'd5);
    @(posedge clk); #1 req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("bp_drain", exp_q.size(), 32'd0);

    // Push and pop on the same edge at count=1.
    rsp_ready = 1'b0;
    issue(32'd100, 32'd23, ALU_ADD);
    repeat (2) @(negedge clk);
    chk("pp_first", rsp_data, 32'd123);
    @(posedge clk); #1;
    issue(32'hFFFF0000, 32'h0000FFFF, ALU_OR);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("pp_valid", 32'(rsp_valid), 32'd1);
    chk("pp_head_new", rsp_data, 32'hFFFFFFFF);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("pp_count_one", 32'(rsp_valid), 32'd0);

    // Randomized traffic with random consumer stalls.
    @(posedge clk); #1;
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++)
      issue($urandom, $urandom, 2'($urandom_range(0, 3)));
    rnd_on = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("rnd_drain", exp_q.size(), 32'd0);

    // Reset mid-operation with one result buffered.
    rsp_ready = 1'b0;
    issue(32'd1, 32'd2, ALU_ADD);
    repeat (2) @(negedge clk);
    chk("mr_buffered", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    issue(32'd3, 32'd4, ALU_ADD);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_alu_b", alu_b, 32'd0);
    chk("mr_alu_sel", 32'(alu_sel), 32'd0);
    rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mr_no_stale", 32'(rsp_valid), 32'd0);
    end

    // SETTLE=4 timing.
    @(posedge clk); #1;
    s4_rsp_ready = 1'b1;
    s4_req_a = 32'h12345678; s4_req_b = 32'h11111111;
    s4_req_sel = ALU_SUB; s4_req_valid = 1'b1;
    got_rdy = 1'b0;
    for (int i = 0; i < 20 && !got_rdy; i++) begin
      @(negedge clk);
      got_rdy = s4_req_ready;
    end
    chk("s4_accept", 32'(got_rdy), 32'd1);
    @(posedge clk); #1 s4_req_valid = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s4_busy) busy_n++;
      chk("s4_no_early", 32'(s4_rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("s4_rsp_valid", 32'(s4_rsp_valid), 32'd1);
    chk("s4_rsp_data", s4_rsp_data, 32'h01234567);
    chk("s4_rsp_sel", 32'(s4_rsp_sel), 32'(ALU_SUB));
    chk("s4_busy_end", 32'(s4_busy), 32'd0);
    chk("s4_busy_cycles", busy_n, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator side of the ALU operand interface (a, b, sel → out).
- Accepts operation requests over a valid/ready handshake and drives registered operands and select onto the combinational ALU.
- Waits a fixed settle interval, captures the ALU result, and returns it through a 2-entry response buffer with valid/ready.
- Sits between the multi-cycle MIPS control path and the ALU, so the ALU can be exercised and timed from a sequential context.

Parameters:
- WIDTH, 32, data width of operands and result.
- SETTLE, 1, clock cycles operands are held on the ALU before capture; legal range 1..15; 0 is illegal (elaboration error).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request this cycle.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_sel  in  2  ALU operation select.
- alu_a  out  WIDTH  operand A to ALU (registered).
- alu_b  out  WIDTH  operand B to ALU (registered).
- alu_sel  out  2  select to ALU (registered).
- alu_out  in  WIDTH  ALU combinational result.
- rsp_valid  out  1  response buffer non-empty.
- rsp_ready  in  1  consumer takes the head response.
- rsp_data  out  WIDTH  head result.
- rsp_sel  out  2  select that produced the head result.
- busy  out  1  operation in flight.

Behaviour:
- Reset is synchronous and active-high; all state clears on the clock edge where rst=1:
  - state=IDLE, settle counter=0, buffer emptied.
  - alu_a=alu_b=0, alu_sel=2'b00.
  - rsp_valid=0, rsp_data=0, rsp_sel=0, busy=0.
  - req_ready=0 while rst=1.
- States:
  - IDLE: req_ready = (buffer count < 2). On req_valid && req_ready at edge N, register req_a/req_b/req_sel onto alu_a/alu_b/alu_sel, load counter=SETTLE, go to WAIT.
  - WAIT: busy=1, req_ready=0. Counter decrements each edge. At the edge where counter==1 (edge N+SETTLE), push {alu_out, alu_sel} into the buffer and return to IDLE.
- Latency: rsp_valid rises after edge N+SETTLE when the buffer was empty.
- Throughput: next accept no earlier than edge N+SETTLE+1, i.e. one operation per SETTLE+1 cycles.
- alu_a/alu_b/alu_sel hold their last values in IDLE; they are not cleared after an operation.
- Response buffer:
  - 2-entry FIFO; rsp_valid = count > 0; rsp_data/rsp_sel show the head entry.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Only one op is in flight and accept requires count < 2, so a push never meets a full buffer.
  - Pop when empty is ignored.
- Backpressure: with rsp_ready held low, at most 2 results are buffered. req_ready stays 0 while count==2 and reasserts the cycle after a pop.
- Reset mid-operation: in-flight op and buffered results are discarded; no rsp_valid pulse follows.
- Arithmetic: the driver does none. rsp_data is exactly alu_out sampled at the capture edge.

Decomposition:
- Shared package alu_pkg holds:
  - select constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - the driver state enum;
  - the WIDTH default.
- One sub-module, alu_rsp_fifo: 2-entry synchronous FIFO, WIDTH+2 bits wide, with push/pop/count and the same clk/rst.

Test Plan (ALU DUT instantiated behind the driver, SETTLE=1 unless noted):
- Reset then a=0x000003E8, b=0x000007D0, sel=00 → req_ready=1 after reset; alu_a/alu_b/alu_sel update the cycle after accept; rsp_valid rises 1 cycle later with rsp_data=0x00000BB8, rsp_sel=00.
- Back-to-back ops with rsp_ready=1:
  - sel=01, a=0x11111111, b=0x44220EA1 → 0xCCEF0270;
  - sel=10, a=0xA0A0A0A0, b=0x00213120 → 0x00202020;
  - sel=11, a=0xF0F0F0F0, b=0x15741674 → 0xF5F4F6F4;
  - required: results in order, req_ready low during every WAIT.
- rsp_ready=0 with three requests offered → two results buffered and req_ready=0. Raise rsp_ready for one cycle → one pop, and req_ready returns the next cycle.
- SETTLE=4 → rsp_valid appears exactly 4 cycles after the accept edge; busy high for exactly 4 cycles.
- Assert rst during WAIT and with one result buffered → next cycle rsp_valid=0, busy=0, alu_* = 0, and no stale result ever emerges.
- Simultaneous capture-push and consumer-pop at count=1 → count remains 1 and the head becomes the new result.
